// File: rtl/game_2048_move_sched.sv
// rtl/game_2048_move_sched.sv - arbitrates 2048 move sources, queues moves and paces strobes to the core.
// Optional cheat path enabled by defining GAME2048_CHEAT_EN.
module game_2048_move_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        kbd_valid,
    input  logic [1:0]  kbd_dir,
    input  logic        btn_valid,
    input  logic [1:0]  btn_dir,
    input  logic        cheat_req,
    input  logic [63:0] board_state,
    output logic        move_valid,
    output logic [1:0]  move_dir,
    output logic        cheat_valid,
    output logic        busy,
    output logic        fifo_full,
    output logic [7:0]  drop_cnt,
    output logic        game_won,
    output logic        game_over
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(GAP_CYCLES);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, OVER} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          rr_btn;
    logic          cheat_pending;
    logic          pop, flush, active, wr;
    logic          board_over, board_won;
    logic          both, win_valid, drop_full;
    logic [1:0]    win_dir, drop_inc;
    logic [8:0]    drop_sum;

    // Game is over when the board is full and no neighbour pair (no wrap) can merge.
    always_comb begin
        board_over = 1'b1;
        board_won  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (board_state[4*i +: 4] == 4'd0)  board_over = 1'b0;
            if (board_state[4*i +: 4] == 4'd11) board_won  = 1'b1;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (board_state[16*r+4*c +: 4] == board_state[16*r+4*c+4 +: 4]) board_over = 1'b0;
            end
        end
        for (int i = 0; i < 12; i++) begin
            if (board_state[4*i +: 4] == board_state[4*i+16 +: 4]) board_over = 1'b0;
        end
    end

`ifdef GAME2048_CHEAT_EN
    logic issue_cheat;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        flush      = 1'b0;
`ifdef GAME2048_CHEAT_EN
        issue_cheat = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (board_over) begin
                    flush      = 1'b1;
                    state_next = OVER;
`ifdef GAME2048_CHEAT_EN
                end else if (cheat_pending) begin
                    issue_cheat = 1'b1;
                    state_next  = WAIT;
                    cnt_next    = '0;
`endif
                end else if (count != '0) begin
                    pop        = 1'b1;
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (cnt == LAST_C) state_next = IDLE;
                else               cnt_next   = cnt + CW'(1);
            end
            OVER:    state_next = OVER;
            default: state_next = IDLE;
        endcase
    end

    // Round-robin only matters on a conflict; otherwise the lone requester wins.
    always_comb begin
        active    = (state != OVER);
        both      = kbd_valid & btn_valid;
        win_valid = kbd_valid | btn_valid;
        win_dir   = (both ? rr_btn : btn_valid) ? btn_dir : kbd_dir;
        wr        = active & win_valid & ~flush & (~fifo_full | pop);
        drop_full = active & win_valid & fifo_full & ~pop;
        drop_inc  = {1'b0, active & both} + {1'b0, drop_full};
        drop_sum  = {1'b0, drop_cnt} + {7'b0, drop_inc};
    end

    assign fifo_full = (count == DEPTH_C);
    assign busy      = (state != IDLE) | (count != '0) | cheat_pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= win_dir;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rr_btn     <= 1'b0;
            move_valid <= 1'b0;
            move_dir   <= 2'd0;
            drop_cnt   <= 8'd0;
            game_won   <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            move_valid <= pop;
            if (pop) move_dir <= mem[rd_ptr];
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr)  wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                if (wr && !pop)      count <= count + (AW+1)'(1);
                else if (!wr && pop) count <= count - (AW+1)'(1);
            end
            if (active && both) rr_btn <= ~rr_btn;
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (board_won) game_won  <= 1'b1;
            if (flush)     game_over <= 1'b1;
        end
    end

`ifdef GAME2048_CHEAT_EN
    // Repeated requests before service collapse into a single pending cheat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cheat_pending <= 1'b0;
            cheat_valid   <= 1'b0;
        end else begin
            cheat_valid <= issue_cheat;
            if (flush)       cheat_pending <= 1'b0;
            else if (active) cheat_pending <= (cheat_pending & ~issue_cheat) | cheat_req;
        end
    end
`else
    logic unused_cheat;
    assign unused_cheat  = cheat_req;
    assign cheat_pending = 1'b0;
    assign cheat_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_game_2048_move_sched.sv
// tb/tb_game_2048_move_sched.sv - self-checking bench for game_2048_move_sched against a queue-based model.
module tb_game_2048_move_sched;

    localparam int DEPTH = 4;
    localparam int GAP   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        kbd_valid = 1'b0, btn_valid = 1'b0, cheat_req = 1'b0;
    logic [1:0]  kbd_dir = 2'd0, btn_dir = 2'd0;
    logic [63:0] board_state = 64'd0;
    logic        move_valid, cheat_valid, busy, fifo_full, game_won, game_over;
    logic [1:0]  move_dir;
    logic [7:0]  drop_cnt;

    game_2048_move_sched #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .kbd_valid(kbd_valid), .kbd_dir(kbd_dir),
        .btn_valid(btn_valid), .btn_dir(btn_dir),
        .cheat_req(cheat_req), .board_state(board_state),
        .move_valid(move_valid), .move_dir(move_dir), .cheat_valid(cheat_valid),
        .busy(busy), .fifo_full(fifo_full), .drop_cnt(drop_cnt),
        .game_won(game_won), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int q[$];
    int wait_left, m_drops;
    bit m_over, m_won, m_rr, m_pend, m_mv, m_cv;
    logic [1:0] m_dir;
    int mv_cyc[$], mv_dir[$], cv_cyc[$];
    bit seen_full;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_over(input logic [63:0] b);
        int t[16];
        for (int i = 0; i < 16; i++) t[i] = int'((b >> (4*i)) & 64'hF);
        for (int i = 0; i < 16; i++) if (t[i] == 0) return 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (c < 3 && t[r*4+c] == t[r*4+c+1]) return 1'b0;
                if (r < 3 && t[r*4+c] == t[(r+1)*4+c]) return 1'b0;
            end
        return 1'b1;
    endfunction

    function automatic bit ref_won(input logic [63:0] b);
        for (int i = 0; i < 16; i++) if (((b >> (4*i)) & 64'hF) == 64'd11) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        wait_left = 0; m_drops = 0;
        m_over = 0; m_won = 0; m_rr = 0; m_pend = 0; m_mv = 0; m_cv = 0; m_dir = 2'd0;
    endtask

    // Advance the model across one clock edge, then compare every output.
    task automatic cycle();
        bit idle, bover, pop, chs, flush, full_before, sel_btn;
        logic [1:0] wd;
        idle  = (wait_left == 0) && !m_over;
        bover = ref_over(board_state);
        flush = idle && bover;
        pop   = idle && !bover && !m_pend && q.size() > 0;
        chs   = idle && !bover && m_pend;
        full_before = (q.size() == DEPTH);
        m_mv = pop;
        m_cv = chs;
        if (pop) m_dir = 2'(q.pop_front());
        if (!m_over && (kbd_valid || btn_valid)) begin
            sel_btn = (kbd_valid && btn_valid) ? m_rr : btn_valid;
            wd = sel_btn ? btn_dir : kbd_dir;
            if (kbd_valid && btn_valid) begin
                m_drops++;
                m_rr = !m_rr;
            end
            if (full_before && !pop) m_drops++;
            else if (!flush) q.push_back(int'(wd));
        end
        if (m_drops > 255) m_drops = 255;
`ifdef GAME2048_CHEAT_EN
        if (flush) m_pend = 0;
        else if (!m_over) m_pend = (m_pend && !chs) || cheat_req;
`endif
        if (pop || chs) wait_left = GAP;
        else if (wait_left > 0) wait_left--;
        if (flush) begin
            m_over = 1;
            q.delete();
        end
        if (ref_won(board_state)) m_won = 1;
        @(posedge clk);
        #1;
        cyc++;
        chk("move_valid", move_valid, m_mv);
        chk("move_dir", move_dir, m_dir);
        chk("cheat_valid", cheat_valid, m_cv);
        chk("busy", busy, m_over || wait_left > 0 || q.size() > 0 || m_pend);
        chk("fifo_full", fifo_full, q.size() == DEPTH);
        chk("drop_cnt", drop_cnt, m_drops);
        chk("game_won", game_won, m_won);
        chk("game_over", game_over, m_over);
        if (fifo_full) seen_full = 1;
        if (move_valid) begin
            mv_cyc.push_back(cyc);
            mv_dir.push_back(int'(move_dir));
        end
        if (cheat_valid) cv_cyc.push_back(cyc);
    endtask

    task automatic idle_cycles(input int n);
        kbd_valid = 0; btn_valid = 0; cheat_req = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic kbd_pulse(input logic [1:0] d);
        kbd_valid = 1; kbd_dir = d; btn_valid = 0; cheat_req = 0;
        cycle();
        kbd_valid = 0;
    endtask

    task automatic clear_logs();
        mv_cyc.delete(); mv_dir.delete(); cv_cyc.delete();
    endtask

    initial begin
        logic [63:0] cb;
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_move_valid", move_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_over_won", {game_over, game_won, cheat_valid, fifo_full}, 0);
        reset_n = 1;
        cyc = 0;

        // Single request at cycle 5, second at cycle 6.
        idle_cycles(5);
        kbd_pulse(2'd1);
        kbd_pulse(2'd2);
        idle_cycles(10);
        chk("strobe_count", mv_cyc.size(), 2);
        if (mv_cyc.size() >= 2) begin
            chk("first_strobe_cyc", mv_cyc[0], 7);
            chk("first_strobe_dir", mv_dir[0], 1);
            chk("second_strobe_cyc", mv_cyc[1], 12);
            chk("second_strobe_dir", mv_dir[1], 2);
        end

        // Two conflicts: kbd wins first, btn wins second.
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            kbd_valid = 1; kbd_dir = 2'd0; btn_valid = 1; btn_dir = 2'd3;
            cycle();
            idle_cycles(9);
        end
        chk("conflict_drops", drop_cnt, 2);
        chk("conflict_count", mv_cyc.size(), 2);
        if (mv_cyc.size() >= 2) begin
            chk("conflict_dir0", mv_dir[0], 0);
            chk("conflict_dir1", mv_dir[1], 3);
        end

        // Six back-to-back requests into a depth-4 FIFO: exactly one drop.
        clear_logs();
        seen_full = 0;
        for (int k = 0; k < 6; k++) kbd_pulse(2'(k));
        idle_cycles(30);
        chk("burst_full_seen", seen_full, 1);
        chk("burst_drops", drop_cnt, 3);
        chk("burst_count", mv_cyc.size(), 5);
        if (mv_cyc.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("burst_dir", mv_dir[k], k % 4);
            for (int k = 1; k < 5; k++) chk("burst_gap", mv_cyc[k] - mv_cyc[k-1], 5);
        end

        // 2048 tile appears during WAIT; play continues.
        clear_logs();
        kbd_pulse(2'd3);
        idle_cycles(1);
        board_state[23:20] = 4'd11;
        idle_cycles(1);
        chk("won_next_cycle", game_won, 1);
        kbd_pulse(2'd2);
        idle_cycles(10);
        chk("won_moves_continue", mv_cyc.size(), 2);

        // Randomized traffic on boards that always keep an empty tile.
        for (int k = 0; k < 1500; k++) begin
            if (k % 40 == 0) board_state = {$urandom, $urandom} & ~64'hF;
            kbd_valid = ($urandom_range(0, 3) == 0);
            btn_valid = ($urandom_range(0, 4) == 0);
            kbd_dir   = 2'($urandom);
            btn_dir   = 2'($urandom);
            cheat_req = ($urandom_range(0, 15) == 0);
            cycle();
        end
        idle_cycles(40);

        // Cheat raised during WAIT with a move queued.
        clear_logs();
        kbd_pulse(2'd0);
        kbd_pulse(2'd1);
        cheat_req = 1;
        cycle();
        cheat_req = 0;
        idle_cycles(20);
        chk("cheat_moves", mv_cyc.size(), 2);
`ifdef GAME2048_CHEAT_EN
        chk("cheat_count", cv_cyc.size(), 1);
        if (mv_cyc.size() >= 2 && cv_cyc.size() >= 1) begin
            chk("cheat_before_move", cv_cyc[0], mv_cyc[0] + GAP + 1);
            chk("move_after_cheat", mv_cyc[1], cv_cyc[0] + GAP + 1);
        end
`else
        chk("cheat_never", cv_cyc.size(), 0);
        if (mv_cyc.size() >= 2) chk("move_gap_nocheat", mv_cyc[1] - mv_cyc[0], GAP + 1);
`endif

        // Asynchronous reset while a strobe is high.
        board_state = 64'd0;
        kbd_pulse(2'd1);
        kbd_pulse(2'd2);
        kbd_pulse(2'd3);
        n = 0;
        while (!move_valid && n < 6) begin
            cycle();
            n++;
        end
        chk("reset_setup_strobe", move_valid, 1);
        reset_n = 0;
        #1;
        chk("async_rst_strobe", move_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_state", {fifo_full, game_won, game_over}, 0);
        chk("async_rst_drops", drop_cnt, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        model_reset();

        // Board locks up during WAIT with moves queued: flush and freeze.
        clear_logs();
        kbd_pulse(2'd0);
        kbd_pulse(2'd1);
        kbd_pulse(2'd2);
        cb = 64'd0;
        for (int i = 0; i < 16; i++) cb[4*i +: 4] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd2 : 4'd1;
        board_state = cb;
        idle_cycles(8);
        chk("over_set", game_over, 1);
        chk("over_fifo_flushed", fifo_full, 0);
        chk("over_single_move", mv_cyc.size(), 1);
        for (int k = 0; k < 8; k++) begin
            kbd_valid = 1; btn_valid = 1; cheat_req = 1;
            kbd_dir = 2'($urandom); btn_dir = 2'($urandom);
            cycle();
        end
        idle_cycles(10);
        chk("over_no_drops", drop_cnt, 0);
        chk("over_no_strobes", mv_cyc.size(), 1);
        chk("over_no_cheat", cv_cyc.size(), 0);
        chk("over_sticky", game_over, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
